eth_phy_10g_link_ctrl: RTL and testbench
========================================

// Module: eth_phy_10g_link_ctrl
// PURPOSE
//  10GBASE-R RX link bring-up/recovery sequencer beside eth_phy_10g.
//  Drives the PHY RX reset, waits for block lock and stable rx_status, declares link up.
//  On lock loss, high BER or SERDES reset request, re-runs bring-up with exponential backoff.
//  Gives up after MAX_RETRIES consecutive failures.
// PARAMETERS
//  RESET_CYCLES   16    cycles phy_rst held high per attempt; also base backoff unit
//  LOCK_TIMEOUT   1024  cycles allowed in WAIT_LOCK before the attempt fails
//  STABLE_CYCLES  256   cycles lock must hold, high_ber stays low, before rx_status is sampled
//  MAX_RETRIES    7     consecutive failed attempts before FAIL (1..15)
//  CNT_WIDTH      16    width of internal timer; all timer loads saturate to 2^CNT_WIDTH-1
// PORTS
//  rx_clk              in   1   single clock (PHY RX clock domain)
//  rx_rst              in   1   synchronous, active-high reset
//  cfg_enable          in   1   1 = run bring-up; 0 = hold PHY in reset (DISABLED)
//  rx_block_lock       in   1   from PHY
//  rx_high_ber         in   1   from PHY
//  rx_status           in   1   from PHY
//  serdes_rx_reset_req in   1   from PHY; treated as link fault
//  phy_rst             out  1   drives PHY rx_rst
//  link_up             out  1   high only in LINK_UP
//  link_fail           out  1   high only in FAIL
//  state               out  3   encoded state (see BEHAVIOUR)
//  retry_count         out  4   consecutive failed attempts
// BEHAVIOUR
//  - Moore FSM; outputs decoded from state register: input sampled at edge N -> output change after edge N.
//  - States: DISABLED=0 RESET=1 WAIT_LOCK=2 WAIT_STABLE=3 LINK_UP=4 BACKOFF=5 FAIL=6.
//  - rx_rst: state=DISABLED, timer=0, retry_count=0; phy_rst=1, link_up=0, link_fail=0.
//  - cfg_enable=0 in any state -> DISABLED next cycle; retry_count cleared. Highest priority after rx_rst.
//  - DISABLED: cfg_enable=1 -> RESET, timer=RESET_CYCLES-1.
//  - RESET: phy_rst=1; timer==0 -> WAIT_LOCK, timer=LOCK_TIMEOUT-1; else decrement.
//  - WAIT_LOCK: lock && !high_ber -> WAIT_STABLE, timer=STABLE_CYCLES-1.
//    timer==0 -> RETRY. Otherwise decrement. Lock wins over simultaneous timeout.
//  - WAIT_STABLE:
//    !lock || high_ber || serdes_rx_reset_req -> RETRY.
//    Else timer==0: rx_status ? LINK_UP : RETRY.
//  - LINK_UP: retry_count cleared on entry.
//    !lock || high_ber || serdes_rx_reset_req -> RESET, timer=RESET_CYCLES-1; not counted as a retry.
//  - RETRY action (not a state), evaluated using the pre-increment retry_count r:
//    r+1 == MAX_RETRIES -> FAIL;
//    else BACKOFF, timer=min(RESET_CYCLES<<r, 2^CNT_WIDTH-1)-1.
//    retry_count = r+1 in both cases.
//  - BACKOFF: phy_rst=1; timer==0 -> RESET, timer=RESET_CYCLES-1.
//  - FAIL: phy_rst=1, link_fail=1; exits only via cfg_enable=0 or rx_rst.
//  - phy_rst=0 only in WAIT_LOCK, WAIT_STABLE and LINK_UP.
//  - retry_count never exceeds MAX_RETRIES.
// CONFIGURATION
//  ETH_PHY_LINK_STATS_EN defined: adds outputs
//    link_drop_count[15:0]: increments on each LINK_UP exit caused by a fault.
//    attempt_count[15:0]: increments on each RESET entry.
//    Both saturate at 16'hFFFF, cleared only by rx_rst (not by cfg_enable).
//  Macro undefined: ports and counters absent; FSM behaviour identical.
// STRUCTURE
//  Package eth_phy_10g_link_pkg: state encoding constants (3-bit), STATE_W.
//  Sub-module eth_phy_10g_link_timer: CNT_WIDTH down-counter with load, dec, zero flag.
//  FSM and retry logic live in this module.
// TESTING (RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3)
//  1. enable, lock=1 at cycle 6, status=1 -> phy_rst low 4 cycles after RESET entry; link_up exactly 9 cycles after lock.
//  2. lock held 0 -> three attempts separated by BACKOFF of 4 then 8 cycles; link_fail=1, retry_count=3, phy_rst=1.
//  3. In LINK_UP pulse high_ber 1 cycle -> RESET next cycle; retry_count stays 0; link_drop_count=1 (STATS_EN).
//  4. WAIT_STABLE with lock, status=0 at timer expiry -> BACKOFF, retry_count=1.
//  5. cfg_enable=0 mid-WAIT_LOCK, and in FAIL -> DISABLED next cycle, retry_count=0; re-enable restarts at RESET.
//  6. rx_rst asserted during LINK_UP -> next cycle DISABLED, phy_rst=1, stats counters=0.

Source files
------------

// File: rtl/eth_phy_10g_link_pkg.sv
// Shared definitions for the 10GBASE-R RX link bring-up sequencer.
// Contents: FSM state encoding (STATE_W bits) and a saturating helper used
// to clamp timer load values to the counter width.
package eth_phy_10g_link_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_DISABLED    = 3'd0;
  localparam logic [STATE_W-1:0] ST_RESET       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_STABLE = 3'd3;
  localparam logic [STATE_W-1:0] ST_LINK_UP     = 3'd4;
  localparam logic [STATE_W-1:0] ST_BACKOFF     = 3'd5;
  localparam logic [STATE_W-1:0] ST_FAIL        = 3'd6;

  // Clamp v to the largest value representable in w bits (w < 64).
  function automatic logic [63:0] sat_cnt(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/eth_phy_10g_link_timer.sv
// Down-counter used by the link sequencer for all of its waits.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_load       load i_load_val (wins over i_dec)
//   i_load_val   value to load
//   i_dec        decrement by one, holding at zero
//   o_zero_c     combinational flag, counter is zero
module eth_phy_10g_link_timer
  import eth_phy_10g_link_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_zero_c
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Counter register: load has priority, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_WIDTH'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10GBASE-R RX link bring-up / recovery sequencer.
// Holds the PHY RX in reset, waits for block lock and a stable error-free
// period, samples rx_status and declares link up. Faults restart bring-up;
// failed attempts back off exponentially and give up after MAX_RETRIES.
// Ports:
//   rx_clk, rx_rst       clock, synchronous active-high reset
//   cfg_enable           0 forces DISABLED (PHY held in reset)
//   rx_block_lock, rx_high_ber, rx_status, serdes_rx_reset_req  PHY status
//   phy_rst              PHY RX reset
//   link_up / link_fail  high only in LINK_UP / FAIL
//   state                encoded FSM state
//   retry_count          consecutive failed attempts
//   link_drop_count, attempt_count  only with ETH_PHY_LINK_STATS_EN defined
module eth_phy_10g_link_ctrl
  import eth_phy_10g_link_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic               rx_clk,
  input  logic               rx_rst,
  input  logic               cfg_enable,
  input  logic               rx_block_lock,
  input  logic               rx_high_ber,
  input  logic               rx_status,
  input  logic               serdes_rx_reset_req,
  output logic               phy_rst,
  output logic               link_up,
  output logic               link_fail,
  output logic [STATE_W-1:0] state,
  output logic [3:0]         retry_count
`ifdef ETH_PHY_LINK_STATS_EN
  ,
  output logic [15:0]        link_drop_count,
  output logic [15:0]        attempt_count
`endif
);

  localparam logic [CNT_WIDTH-1:0] RST_LOAD =
    CNT_WIDTH'(sat_cnt(64'(RESET_CYCLES) - 64'd1, CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] LOCK_LOAD =
    CNT_WIDTH'(sat_cnt(64'(LOCK_TIMEOUT) - 64'd1, CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] STABLE_LOAD =
    CNT_WIDTH'(sat_cnt(64'(STABLE_CYCLES) - 64'd1, CNT_WIDTH));

  logic [STATE_W-1:0]   r_state;
  logic [3:0]           r_retry;
  logic                 r_phy_rst;
  logic                 r_link_up;
  logic                 r_link_fail;

  logic [STATE_W-1:0]   w_state_nxt;
  logic [3:0]           w_retry_nxt;
  logic                 w_load;
  logic [CNT_WIDTH-1:0] w_load_val;
  logic                 w_dec;
  logic                 w_zero;
  logic                 w_fault;
  logic                 w_last_try;
  logic [63:0]          w_bo_shift;
  logic [CNT_WIDTH-1:0] w_bo_load;

  eth_phy_10g_link_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk        (rx_clk),
    .rst        (rx_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero_c   (w_zero)
  );

  assign w_fault    = !rx_block_lock || rx_high_ber || serdes_rx_reset_req;
  assign w_last_try = ((5'(r_retry) + 5'd1) == 5'(MAX_RETRIES));
  // Backoff doubles per failed attempt, clamped to the timer range.
  assign w_bo_shift = 64'(RESET_CYCLES) << r_retry;
  assign w_bo_load  = CNT_WIDTH'(sat_cnt(w_bo_shift, CNT_WIDTH) - 64'd1);

  // Next-state, retry and timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    if (!cfg_enable) begin
      w_state_nxt = ST_DISABLED;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_DISABLED: begin
          w_state_nxt = ST_RESET;
          w_load      = 1'b1;
          w_load_val  = RST_LOAD;
        end
        ST_RESET: begin
          if (w_zero) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_load      = 1'b1;
            w_load_val  = LOCK_LOAD;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (rx_block_lock && !rx_high_ber) begin
            w_state_nxt = ST_WAIT_STABLE;
            w_load      = 1'b1;
            w_load_val  = STABLE_LOAD;
          end else if (w_zero) begin
            w_state_nxt = w_last_try ? ST_FAIL : ST_BACKOFF;
            w_retry_nxt = r_retry + 4'd1;
            w_load      = !w_last_try;
            w_load_val  = w_bo_load;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_WAIT_STABLE: begin
          if (!w_fault && w_zero && rx_status) begin
            w_state_nxt = ST_LINK_UP;
            w_retry_nxt = 4'd0;
          end else if (w_fault || w_zero) begin
            w_state_nxt = w_last_try ? ST_FAIL : ST_BACKOFF;
            w_retry_nxt = r_retry + 4'd1;
            w_load      = !w_last_try;
            w_load_val  = w_bo_load;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_LINK_UP: begin
          // Link drops restart bring-up without consuming a retry.
          if (w_fault) begin
            w_state_nxt = ST_RESET;
            w_load      = 1'b1;
            w_load_val  = RST_LOAD;
          end
        end
        ST_BACKOFF: begin
          if (w_zero) begin
            w_state_nxt = ST_RESET;
            w_load      = 1'b1;
            w_load_val  = RST_LOAD;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_FAIL: w_state_nxt = ST_FAIL;
        default: w_state_nxt = ST_DISABLED;
      endcase
    end
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_state     <= ST_DISABLED;
      r_retry     <= 4'd0;
      r_phy_rst   <= 1'b1;
      r_link_up   <= 1'b0;
      r_link_fail <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_retry     <= w_retry_nxt;
      r_phy_rst   <= !((w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_WAIT_STABLE) ||
                       (w_state_nxt == ST_LINK_UP));
      r_link_up   <= (w_state_nxt == ST_LINK_UP);
      r_link_fail <= (w_state_nxt == ST_FAIL);
    end
  end

  assign phy_rst     = r_phy_rst;
  assign link_up     = r_link_up;
  assign link_fail   = r_link_fail;
  assign state       = r_state;
  assign retry_count = r_retry;

`ifdef ETH_PHY_LINK_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_attempt_cnt;

  // Saturating statistics; cfg_enable does not clear them.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_drop_cnt    <= 16'd0;
      r_attempt_cnt <= 16'd0;
    end else begin
      if (cfg_enable && (r_state == ST_LINK_UP) && w_fault && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if ((w_state_nxt == ST_RESET) && (r_state != ST_RESET) && (r_attempt_cnt != 16'hFFFF))
        r_attempt_cnt <= r_attempt_cnt + 16'd1;
    end
  end

  assign link_drop_count = r_drop_cnt;
  assign attempt_count   = r_attempt_cnt;
`endif

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Directed bench for eth_phy_10g_link_ctrl with small timing parameters.
module tb_eth_phy_10g_link_ctrl;

  logic       rx_clk = 1'b0;
  logic       rx_rst;
  logic       cfg_enable;
  logic       rx_block_lock;
  logic       rx_high_ber;
  logic       rx_status;
  logic       serdes_rx_reset_req;
  logic       phy_rst;
  logic       link_up;
  logic       link_fail;
  logic [2:0] state;
  logic [3:0] retry_count;
`ifdef ETH_PHY_LINK_STATS_EN
  logic [15:0] link_drop_count;
  logic [15:0] attempt_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  eth_phy_10g_link_ctrl #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .CNT_WIDTH     (16)
  ) dut (
    .rx_clk              (rx_clk),
    .rx_rst              (rx_rst),
    .cfg_enable          (cfg_enable),
    .rx_block_lock       (rx_block_lock),
    .rx_high_ber         (rx_high_ber),
    .rx_status           (rx_status),
    .serdes_rx_reset_req (serdes_rx_reset_req),
    .phy_rst             (phy_rst),
    .link_up             (link_up),
    .link_fail           (link_fail),
    .state               (state),
    .retry_count         (retry_count)
`ifdef ETH_PHY_LINK_STATS_EN
    ,
    .link_drop_count     (link_drop_count),
    .attempt_count       (attempt_count)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rx_rst = 1'b1; cfg_enable = 1'b0; rx_block_lock = 1'b0;
    rx_high_ber = 1'b0; rx_status = 1'b0; serdes_rx_reset_req = 1'b0;
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_phy_rst", 32'(phy_rst), 32'd1);
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_link_fail", 32'(link_fail), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);

    // Clean bring-up
    rx_rst = 1'b0; cfg_enable = 1'b1; rx_status = 1'b1;
    tick(1);
    chk("t1_reset", 32'(state), 32'd1);
    chk("t1_phy_rst_hi", 32'(phy_rst), 32'd1);
    tick(3);
    chk("t1_reset_last", 32'(state), 32'd1);
    tick(1);
    chk("t1_wait_lock", 32'(state), 32'd2);
    chk("t1_phy_rst_lo", 32'(phy_rst), 32'd0);
    rx_block_lock = 1'b1;
    tick(1);
    chk("t1_wait_stable", 32'(state), 32'd3);
    tick(7);
    chk("t1_not_up_yet", 32'(link_up), 32'd0);
    tick(1);
    chk("t1_link_up", 32'(link_up), 32'd1);
    chk("t1_state_up", 32'(state), 32'd4);
    chk("t1_retry", 32'(retry_count), 32'd0);
`ifdef ETH_PHY_LINK_STATS_EN
    chk("t1_attempts", 32'(attempt_count), 32'd1);
`endif

    // High BER pulse while up
    rx_high_ber = 1'b1;
    tick(1);
    rx_high_ber = 1'b0;
    chk("t3_reset", 32'(state), 32'd1);
    chk("t3_link_up", 32'(link_up), 32'd0);
    chk("t3_retry", 32'(retry_count), 32'd0);
`ifdef ETH_PHY_LINK_STATS_EN
    chk("t3_drops", 32'(link_drop_count), 32'd1);
    chk("t3_attempts", 32'(attempt_count), 32'd2);
`endif
    tick(13);
    chk("t3_relink", 32'(state), 32'd4);

    // Status low at end of stable window
    serdes_rx_reset_req = 1'b1; rx_status = 1'b0;
    tick(1);
    serdes_rx_reset_req = 1'b0;
    chk("t4_reset", 32'(state), 32'd1);
    tick(5);
    chk("t4_wait_stable", 32'(state), 32'd3);
    tick(7);
    chk("t4_still_stable", 32'(state), 32'd3);
    tick(1);
    chk("t4_backoff", 32'(state), 32'd5);
    chk("t4_retry", 32'(retry_count), 32'd1);
    chk("t4_phy_rst", 32'(phy_rst), 32'd1);
    tick(3);
    chk("t4_backoff_end", 32'(state), 32'd5);
    tick(1);
    chk("t4_reset_again", 32'(state), 32'd1);

    // Disable mid-WAIT_LOCK
    rx_block_lock = 1'b0;
    tick(6);
    chk("t5a_wait_lock", 32'(state), 32'd2);
    cfg_enable = 1'b0;
    tick(1);
    chk("t5a_disabled", 32'(state), 32'd0);
    chk("t5a_retry", 32'(retry_count), 32'd0);
    chk("t5a_phy_rst", 32'(phy_rst), 32'd1);

    // No lock: three attempts then FAIL
    cfg_enable = 1'b1;
    tick(1);
    chk("t2_reset", 32'(state), 32'd1);
    tick(24);
    chk("t2_backoff1", 32'(state), 32'd5);
    chk("t2_retry1", 32'(retry_count), 32'd1);
    tick(3);
    chk("t2_backoff1_end", 32'(state), 32'd5);
    tick(1);
    chk("t2_reset2", 32'(state), 32'd1);
    tick(24);
    chk("t2_backoff2", 32'(state), 32'd5);
    chk("t2_retry2", 32'(retry_count), 32'd2);
    tick(7);
    chk("t2_backoff2_end", 32'(state), 32'd5);
    tick(1);
    chk("t2_reset3", 32'(state), 32'd1);
    tick(23);
    chk("t2_last_wait", 32'(state), 32'd2);
    tick(1);
    chk("t2_fail", 32'(state), 32'd6);
    chk("t2_link_fail", 32'(link_fail), 32'd1);
    chk("t2_retry3", 32'(retry_count), 32'd3);
    chk("t2_phy_rst", 32'(phy_rst), 32'd1);
`ifdef ETH_PHY_LINK_STATS_EN
    chk("t2_attempts", 32'(attempt_count), 32'd7);
`endif
    tick(5);
    chk("t2_fail_hold", 32'(state), 32'd6);

    // Disable from FAIL, re-enable
    cfg_enable = 1'b0;
    tick(1);
    chk("t5b_disabled", 32'(state), 32'd0);
    chk("t5b_retry", 32'(retry_count), 32'd0);
    chk("t5b_link_fail", 32'(link_fail), 32'd0);
    cfg_enable = 1'b1; rx_block_lock = 1'b1; rx_status = 1'b1;
    tick(1);
    chk("t5b_restart", 32'(state), 32'd1);
    tick(13);
    chk("t6_up", 32'(state), 32'd4);

    // Reset while up
    rx_rst = 1'b1;
    tick(1);
    chk("t6_disabled", 32'(state), 32'd0);
    chk("t6_phy_rst", 32'(phy_rst), 32'd1);
    chk("t6_link_up", 32'(link_up), 32'd0);
`ifdef ETH_PHY_LINK_STATS_EN
    chk("t6_drops", 32'(link_drop_count), 32'd0);
    chk("t6_attempts", 32'(attempt_count), 32'd0);
`endif
    rx_rst = 1'b0; cfg_enable = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
